// File: rtl/turbo_iter_sched.sv
// -----------------------------------------------------------------------------
// turbo_iter_sched
//
// Iteration scheduler for the turbo decoder core. Loads a frame of BEATS input
// beats, then alternates the shared SISO engine between the natural-order pass
// (DEC1) and the interleaved pass (DEC2). A frame ends on MAX_ITER completed
// iterations, on convergence of the hard decisions (after MIN_ITER
// iterations), or on a SISO timeout.
//
// Handshake: siso_go_o is a one-cycle start pulse. siso_done_i is only looked
// at while waiting for the SISO; the earliest accepted done is the cycle after
// the go pulse. The done cycle itself counts as a wait cycle.
//
// Ports:
//   clk_p_i       clock, rising edge
//   reset_i       synchronous active-high reset
//   start_i       frame start, honoured in IDLE or DONE only
//   beat_valid_i  input beat present this cycle
//   load_we_o     frame buffer write strobe (combinational)
//   load_idx_o    beat index of the current write
//   siso_go_o     one-cycle SISO start pulse
//   siso_sel_o    0 = DEC1 operands, 1 = DEC2 operands
//   ext_clr_o     zero the extrinsic input (first DEC1 of a frame)
//   siso_done_i   SISO completion pulse
//   hard_i        hard decisions from the deinterleaved DEC2 output
//   data_o        final decision word, held until the next frame completes
//   done_o        frame complete, held until the next start
//   iter_o        completed iteration count
//   early_o       frame ended by convergence
//   err_o         frame ended by SISO timeout
//   dbg_state     current FSM state, for observation only
// -----------------------------------------------------------------------------
module turbo_iter_sched #(
    parameter int MAX_ITER     = 16,
    parameter int MIN_ITER     = 2,
    parameter int BEATS        = 4,
    parameter int DATA_W       = 5,
    parameter int SISO_TIMEOUT = 255
) (
    input  logic              clk_p_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              beat_valid_i,
    output logic              load_we_o,
    output logic [1:0]        load_idx_o,
    output logic              siso_go_o,
    output logic              siso_sel_o,
    output logic              ext_clr_o,
    input  logic              siso_done_i,
    input  logic [DATA_W-1:0] hard_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic [5:0]        iter_o,
    output logic              early_o,
    output logic              err_o,
    output logic [2:0]        dbg_state
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Wait counter value seen on the last permitted wait cycle.
    localparam logic [7:0] TMO_LAST = 8'(SISO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        D1_GO   = 3'd2,
        D1_WAIT = 3'd3,
        D2_GO   = 3'd4,
        D2_WAIT = 3'd5,
        CHECK   = 3'd6,
        DONE    = 3'd7
    } state_t;

    state_t            state;
    logic [BW-1:0]     beat_cnt;
    logic [5:0]        iter_cnt;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] prev_hard;
    logic              prev_valid;

    logic [6:0]        iter_next;
    logic              conv;

    // One bit wider than iter_cnt so MAX_ITER=63 compares without wrap.
    assign iter_next = {1'b0, iter_cnt} + 7'd1;

    // Convergence needs a previous DEC2 result from this same frame.
    assign conv = prev_valid && (hard_i == prev_hard) && (iter_next >= 7'(MIN_ITER));

    assign load_we_o  = (state == LOAD) && beat_valid_i;
    assign load_idx_o = 2'(beat_cnt);
    assign iter_o     = iter_cnt;
    assign dbg_state  = state;

    always_ff @(posedge clk_p_i) begin
        if (reset_i) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            iter_cnt   <= '0;
            wait_cnt   <= '0;
            prev_hard  <= '0;
            prev_valid <= 1'b0;
            siso_go_o  <= 1'b0;
            siso_sel_o <= 1'b0;
            ext_clr_o  <= 1'b0;
            data_o     <= '0;
            done_o     <= 1'b0;
            early_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            // Go and clear are single-cycle pulses raised on entry to a GO state.
            siso_go_o <= 1'b0;
            ext_clr_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= LOAD;
                        beat_cnt   <= '0;
                        iter_cnt   <= '0;
                        wait_cnt   <= '0;
                        prev_valid <= 1'b0;
                    end
                end

                LOAD: begin
                    if (beat_valid_i) begin
                        if (beat_cnt == BW'(BEATS - 1)) begin
                            beat_cnt   <= '0;
                            state      <= D1_GO;
                            siso_go_o  <= 1'b1;
                            siso_sel_o <= 1'b0;
                            ext_clr_o  <= (iter_cnt == 6'd0);
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                D1_GO: begin
                    wait_cnt <= '0;
                    state    <= D1_WAIT;
                end

                D1_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A done on the timeout cycle is still accepted.
                    if (siso_done_i) begin
                        state      <= D2_GO;
                        siso_go_o  <= 1'b1;
                        siso_sel_o <= 1'b1;
                    end else if (wait_cnt == TMO_LAST) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end
                end

                D2_GO: begin
                    wait_cnt <= '0;
                    state    <= D2_WAIT;
                end

                D2_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (siso_done_i) begin
                        state      <= CHECK;
                        siso_sel_o <= 1'b0;
                    end else if (wait_cnt == TMO_LAST) begin
                        state      <= DONE;
                        siso_sel_o <= 1'b0;
                        done_o     <= 1'b1;
                        err_o      <= 1'b1;
                    end
                end

                CHECK: begin
                    iter_cnt   <= iter_next[5:0];
                    prev_hard  <= hard_i;
                    prev_valid <= 1'b1;
                    // Convergence outranks the iteration limit so the final
                    // iteration still reports early_o when it converged.
                    if (conv) begin
                        state   <= DONE;
                        done_o  <= 1'b1;
                        early_o <= 1'b1;
                        data_o  <= hard_i;
                    end else if (iter_next == 7'(MAX_ITER)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        data_o <= hard_i;
                    end else begin
                        state      <= D1_GO;
                        siso_go_o  <= 1'b1;
                        siso_sel_o <= 1'b0;
                        ext_clr_o  <= 1'b0;
                    end
                end

                DONE: begin
                    // data_o is left alone so the last result stays visible.
                    if (start_i) begin
                        state      <= LOAD;
                        done_o     <= 1'b0;
                        early_o    <= 1'b0;
                        err_o      <= 1'b0;
                        iter_cnt   <= '0;
                        wait_cnt   <= '0;
                        prev_valid <= 1'b0;
                        beat_cnt   <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_iter_sched.sv
// -----------------------------------------------------------------------------
// tb_turbo_iter_sched
//
// Bench for turbo_iter_sched with MAX_ITER=3, MIN_ITER=2, SISO_TIMEOUT=20.
// A frame is described by per-iteration SISO latencies (0 = never answers)
// and per-iteration hard decisions. The reference model walks those rules to
// list the expected go pulses (sel, clr, cycle) and the expected frame result.
// A responder process answers go pulses and checks them against exp_q.
// -----------------------------------------------------------------------------
module tb_turbo_iter_sched;

    localparam int MAX_ITER = 3;
    localparam int MIN_ITER = 2;
    localparam int BEATS    = 4;
    localparam int DATA_W   = 5;
    localparam int TMO      = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              reset_i;
    logic              start_i;
    logic              beat_valid_i;
    logic              load_we_o;
    logic [1:0]        load_idx_o;
    logic              siso_go_o;
    logic              siso_sel_o;
    logic              ext_clr_o;
    logic              siso_done_i;
    logic [DATA_W-1:0] hard_i;
    logic [DATA_W-1:0] data_o;
    logic              done_o;
    logic [5:0]        iter_o;
    logic              early_o;
    logic              err_o;
    logic [2:0]        dbg_state;

    turbo_iter_sched #(
        .MAX_ITER    (MAX_ITER),
        .MIN_ITER    (MIN_ITER),
        .BEATS       (BEATS),
        .DATA_W      (DATA_W),
        .SISO_TIMEOUT(TMO)
    ) dut (
        .clk_p_i     (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .beat_valid_i(beat_valid_i),
        .load_we_o   (load_we_o),
        .load_idx_o  (load_idx_o),
        .siso_go_o   (siso_go_o),
        .siso_sel_o  (siso_sel_o),
        .ext_clr_o   (ext_clr_o),
        .siso_done_i (siso_done_i),
        .hard_i      (hard_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .iter_o      (iter_o),
        .early_o     (early_o),
        .err_o       (err_o),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Expected go pulses: {sel, clr, cycle[29:0]}
    logic [31:0] exp_q[$];

    int                d1_a[MAX_ITER];
    int                d2_a[MAX_ITER];
    logic [DATA_W-1:0] hv_a[MAX_ITER];

    int                exp_done_t;
    int                exp_iter;
    logic              exp_early;
    logic              exp_err;
    logic [DATA_W-1:0] exp_data;

    int go_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Go at cycle t, done accepted at t+d, next go at t+d+1. No answer means
    // DONE at t+TMO+1. CHECK follows the DEC2 done cycle; DONE follows CHECK.
    task automatic build_model(input int tlast);
        int  t;
        int  chk_t;
        bit  cv;
        t = tlast + 1;
        exp_early = 1'b0;
        exp_err   = 1'b0;
        for (int k = 0; k < MAX_ITER; k++) begin
            exp_q.push_back({1'b0, (k == 0), 30'(t)});
            if (d1_a[k] == 0) begin
                exp_err = 1'b1; exp_iter = k; exp_done_t = t + TMO + 1;
                return;
            end
            t = t + d1_a[k] + 1;
            exp_q.push_back({1'b1, 1'b0, 30'(t)});
            if (d2_a[k] == 0) begin
                exp_err = 1'b1; exp_iter = k; exp_done_t = t + TMO + 1;
                return;
            end
            chk_t    = t + d2_a[k] + 1;
            exp_iter = k + 1;
            cv = (k > 0) && (hv_a[k] == hv_a[k-1]) && (k + 1 >= MIN_ITER);
            if (cv || (k + 1 == MAX_ITER)) begin
                exp_early  = cv;
                exp_data   = hv_a[k];
                exp_done_t = chk_t + 1;
                return;
            end
            t = chk_t + 1;
        end
    endtask

    // ---------------- SISO responder / go monitor ----------------
    bit                pend;
    int                due;
    bit                due_d2;
    int                due_k;

    initial begin
        int          k;
        int          d;
        logic [31:0] e;
        siso_done_i = 1'b0;
        hard_i      = '0;
        pend        = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pend        = 1'b0;
                siso_done_i = 1'b0;
            end else begin
                if (siso_go_o) begin
                    if (exp_q.size() == 0) begin
                        check("go_unexpected", siso_go_o, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("go_event", {siso_sel_o, ext_clr_o, 30'(cyc)}, e);
                    end
                    k = go_idx / 2;
                    d = 0;
                    if (k < MAX_ITER) d = (go_idx % 2 == 1) ? d2_a[k] : d1_a[k];
                    if (d > 0) begin
                        pend   = 1'b1;
                        due    = cyc + d;
                        due_d2 = (go_idx % 2 == 1);
                        due_k  = k;
                    end
                    go_idx++;
                end
                if (pend && cyc == due) begin
                    siso_done_i = 1'b1;
                    pend        = 1'b0;
                    if (due_d2) hard_i = hv_a[due_k];
                end else begin
                    siso_done_i = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_frame(input logic [15:0] pat, input int plen, output int tlast);
        int idx;
        int n;
        bit v;
        idx   = 0;
        n     = 0;
        tlast = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("start_clears_flags", {done_o, early_o, err_o}, 3'b000);
        check("data_held_at_start", data_o, exp_data);
        while (n < 200) begin
            v = (n < plen) ? pat[n] : ($urandom_range(0, 3) != 0);
            beat_valid_i = v;
            #1;
            check("load_we", load_we_o, v);
            if (v) begin
                check("load_idx", load_idx_o, idx);
                idx++;
            end
            n++;
            if (idx == BEATS) begin
                tlast = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", done_o, 1'b1);
        check("done_cycle", cyc, exp_done_t);
        check("iter", iter_o, exp_iter);
        check("early", early_o, exp_early);
        check("err", err_o, exp_err);
        check("data", data_o, exp_data);
        check("missing_gos", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_frame(input logic [15:0] pat, input int plen, input bit poke_start);
        int tlast;
        go_idx = 0;
        load_frame(pat, plen, tlast);
        build_model(tlast);
        @(negedge clk);
        beat_valid_i = 1'b0;
        if (poke_start) begin
            // Lands in D1_WAIT; must be ignored.
            @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        wait_done();
    endtask

    task automatic set_iter(input int k, input int a, input int b, input logic [DATA_W-1:0] h);
        d1_a[k] = a;
        d2_a[k] = b;
        hv_a[k] = h;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tlast;
        int n;
        reset_i      = 1'b1;
        start_i      = 1'b0;
        beat_valid_i = 1'b0;
        exp_data     = '0;
        go_idx       = 0;
        for (int k = 0; k < MAX_ITER; k++) set_iter(k, 1, 1, '0);

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {done_o, early_o, err_o, siso_go_o, siso_sel_o, ext_clr_o,
               load_we_o, load_idx_o, iter_o, data_o}, 0);
        reset_i = 1'b0;

        // Full run to MAX_ITER, decisions change every iteration, 11-cycle iterations.
        set_iter(0, 4, 4, 5'd1);
        set_iter(1, 4, 4, 5'd2);
        set_iter(2, 4, 4, 5'd3);
        run_frame(16'h0, 0, 1'b0);

        // Constant decisions converge at MIN_ITER.
        for (int k = 0; k < MAX_ITER; k++)
            set_iter(k, $urandom_range(1, 6), $urandom_range(1, 6), 5'b10110);
        run_frame(16'h0, 0, 1'b0);

        // DEC2 never answers on the first iteration.
        set_iter(0, 4, 0, 5'd7);
        run_frame(16'h0, 0, 1'b0);

        // DEC2 answers on the timeout cycle itself.
        set_iter(0, 3, TMO, 5'd9);
        set_iter(1, 2, 2, 5'd9);
        set_iter(2, 2, 2, 5'd4);
        run_frame(16'h0, 0, 1'b0);

        // Gapped beats 1,0,1,1,0,1 plus a stray start during D1_WAIT.
        set_iter(0, 4, 3, 5'd12);
        set_iter(1, 3, 5, 5'd13);
        set_iter(2, 2, 2, 5'd14);
        run_frame(16'b101101, 6, 1'b1);

        // Reset during the first D2_WAIT.
        go_idx = 0;
        set_iter(0, 3, 0, 5'd21);
        load_frame(16'h0, 0, tlast);
        build_model(tlast);
        @(negedge clk);
        beat_valid_i = 1'b0;
        n = 0;
        while (!(siso_go_o && siso_sel_o) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("d2_go_before_reset", siso_go_o && siso_sel_o, 1'b1);
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        #1;
        check("mid_frame_reset_outputs",
              {done_o, early_o, err_o, siso_go_o, siso_sel_o, ext_clr_o,
               load_we_o, iter_o, data_o}, 0);
        reset_i = 1'b0;
        exp_q.delete();
        exp_data = '0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("idle_after_reset", {siso_go_o, done_o}, 2'b00);
        end

        // Fresh frame after reset.
        set_iter(0, 2, 3, 5'd5);
        set_iter(1, 3, 2, 5'd6);
        set_iter(2, 1, 1, 5'd6);
        run_frame(16'h0, 0, 1'b0);

        // Hold DONE for 20 cycles, then restart.
        repeat (20) @(negedge clk);
        #1;
        check("done_held", done_o, 1'b1);
        check("data_held", data_o, exp_data);

        // Randomized frames.
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < MAX_ITER; k++) begin
                d1_a[k] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
                d2_a[k] = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
                if (k > 0 && $urandom_range(0, 1) == 1) hv_a[k] = hv_a[k-1];
                else hv_a[k] = DATA_W'($urandom_range(0, 31));
            end
            run_frame(16'h0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/turbo_iter_sched.md
# turbo_iter_sched

Iteration scheduler for the turbo decoder core. It loads a frame from the input port, then runs the two SISO half-iterations in sequence on a shared SISO engine: first the natural-order pass (DEC1), then the interleaved pass (DEC2). It repeats until MAX_ITER iterations complete, the hard decisions stop changing, or the SISO hangs. It owns all go/done handshaking with the SISO datapath and the interleaver buffers, and presents the final hard-decision word with a done flag.

## Interface
Parameters:
- MAX_ITER, 16: maximum full iterations (DEC1+DEC2) per frame; range 1..63.
- MIN_ITER, 2: minimum completed iterations before early stop is allowed; range 1..MAX_ITER.
- BEATS, 4: input beats per frame, one 21-bit beat per load cycle.
- DATA_W, 5: hard-decision width.
- SISO_TIMEOUT, 255: maximum WAIT cycles per half-iteration; range 2..255.

Ports (one clock; reset is synchronous and active-high):
- clk_p_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  frame start; honoured only in IDLE or DONE.
- beat_valid_i  in  1  an input beat is present this cycle.
- load_we_o  out  1  write strobe to the frame buffer; combinational = (state==LOAD) & beat_valid_i.
- load_idx_o  out  2  beat index 0..BEATS-1 for the current write.
- siso_go_o  out  1  one-cycle SISO start pulse.
- siso_sel_o  out  1  0 = DEC1 operands (sys, enc1, deinterleaved extrinsic); 1 = DEC2 operands (interleaved sys, enc2, interleaved extrinsic).
- ext_clr_o  out  1  forces extrinsic input to zero; high with siso_go_o on the first DEC1 of a frame only.
- siso_done_i  in  1  SISO completion pulse.
- hard_i  in  DATA_W  sign-derived hard decisions from the deinterleaved DEC2 output.
- data_o  out  DATA_W  registered final decision.
- done_o  out  1  frame complete; held high.
- iter_o  out  6  completed iteration count.
- early_o  out  1  frame ended by convergence.
- err_o  out  1  frame ended by SISO timeout.

## Operation
- States: IDLE, LOAD, D1_GO, D1_WAIT, D2_GO, D2_WAIT, CHECK, DONE.
- IDLE: start_i → LOAD. beat_cnt, iter_cnt and wait_cnt are cleared.
- LOAD: each cycle with beat_valid_i=1:
  - load_we_o=1 and load_idx_o=beat_cnt; beat_cnt increments.
  - When the beat with index BEATS-1 is written → D1_GO.
  - Cycles without beat_valid_i change nothing.
- D1_GO (1 cycle): siso_go_o=1, siso_sel_o=0, ext_clr_o=(iter_cnt==0). Clears wait_cnt. → D1_WAIT.
- D1_WAIT: siso_sel_o held 0; wait_cnt increments each cycle.
  - siso_done_i=1 → D2_GO.
  - Else, if this is WAIT cycle number SISO_TIMEOUT → DONE with err_o=1.
  - If siso_done_i and the timeout coincide, done wins.
- D2_GO / D2_WAIT: same as D1, with siso_sel_o=1 and ext_clr_o=0. On done → CHECK; timeout → DONE with err.
- CHECK (1 cycle):
  - iter_cnt ← iter_cnt+1; prev_hard ← hard_i; prev_valid ← 1.
  - conv = prev_valid & (hard_i==prev_hard) & (iter_cnt+1 ≥ MIN_ITER).
  - conv → DONE with early_o=1. Else iter_cnt+1==MAX_ITER → DONE. Else → D1_GO.
  - conv has priority over MAX_ITER, so early_o=1 on the final iteration if converged.
- Entry to DONE from CHECK: data_o ← hard_i. On timeout entry, data_o keeps its previous value.
- DONE: done_o=1, siso_go_o=0.
  - start_i → LOAD; done_o, early_o and err_o clear that edge; iter_cnt, prev_valid and beat_cnt clear.
  - data_o holds until the next DONE entry.
- start_i outside IDLE/DONE is ignored. siso_done_i outside WAIT states is ignored.
- iter_o = iter_cnt at all times.

## Timing
- Reset value of all outputs: 0. State resets to IDLE; prev_valid=0.
- reset_i mid-frame: IDLE on the next edge. No further siso_go_o. done_o stays 0 until a new frame completes.
- Load-to-go: the last beat at cycle t puts siso_go_o=1 at t+1.
- Earliest siso_done_i is accepted the cycle after siso_go_o.
- Iteration length = 1 + d1 + 1 + d2 + 1 cycles. d1 and d2 are WAIT cycles, each including its done cycle.
- done_o rises the cycle after CHECK (or after the timeout cycle).

## Test plan
- MAX_ITER=3, MIN_ITER=3, SISO model asserts done 4 cycles after go, hard_i changes every iteration:
  - exactly 6 go pulses with sel 0,1,0,1,0,1; ext_clr_o only on the first;
  - done_o with iter_o=3, early_o=0, data_o=last hard_i; each iteration is 11 cycles.
- hard_i constant 5'b10110, MIN_ITER=2, MAX_ITER=16: 4 go pulses, done_o with iter_o=2, early_o=1, data_o=5'b10110.
- SISO never asserts done in the first D2_WAIT: err_o=1 and done_o=1 exactly SISO_TIMEOUT+1 cycles after the D2 go pulse, iter_o=0. Repeat with done on the timeout cycle: no error, proceeds to CHECK.
- beat_valid_i with gaps (1,0,1,1,0,1): load_idx_o 0,1,2,3 only on valid cycles; D1_GO one cycle after the 4th beat; a start_i pulse during D1_WAIT has no effect.
- reset_i asserted in D2_WAIT for 1 cycle: all outputs 0 the next cycle. A fresh frame then runs with ext_clr_o on its first go and iter_o restarting from 0.
- Frame completes, done_o held 20 cycles, then start_i: done_o, early_o and err_o clear on the next cycle, LOAD accepts 4 beats, and data_o holds the old value until the new DONE.
